// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch sequencer states
//   OP_*          : opcode values the fetch unit must recognise (operand-bearing
//                   opcodes and endop); all other opcodes are single-word.
package instr_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_OP    = 3'd2,
      ST_OPD   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_HALT  = 3'd5
   } fetch_state_e;

   localparam logic [7:0] OP_LOADIM = 8'd38;
   localparam logic [7:0] OP_JUMPZ  = 8'd41;
   localparam logic [7:0] OP_JUMPNZ = 8'd48;
   localparam logic [7:0] OP_JUMP   = 8'd49;
   localparam logic [7:0] OP_ENDOP  = 8'd51;

endpackage

// File: rtl/instr_fetch_len_decode.sv
// Instruction length decoder (combinational).
//   opcode_i   : 8-bit opcode
//   two_word_o : opcode is followed by a 16-bit operand word
//   is_endop_o : opcode terminates the program
module instr_fetch_len_decode
   import instr_fetch_pkg::*;
(
   input  logic [7:0] opcode_i,
   output logic       two_word_o,
   output logic       is_endop_o
);

   always_comb begin
      two_word_o = (opcode_i == OP_LOADIM) || (opcode_i == OP_JUMPZ) ||
                   (opcode_i == OP_JUMPNZ) || (opcode_i == OP_JUMP);
      is_endop_o = (opcode_i == OP_ENDOP);
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode (and optional operand) words from a
// 1-cycle-latency instruction memory, presents complete instructions to the
// control unit via valid/ready, accepts branch redirects, halts on endop or
// an out-of-range fetch.
//   clk, reset_n          : clock, async active-low reset
//   start                 : begin fetching at RESET_PC (IDLE only)
//   mem_addr/mem_write_en : memory address, write enable (always 0)
//   mem_rdata             : read word, valid the cycle after the address
//   ir_opcode/ir_operand  : presented instruction
//   ir_valid/ir_ready     : presentation handshake
//   redirect_en/_addr     : branch redirect
//   pc_out                : address of the presented/in-flight opcode word
//   halted, fault         : HALT state, sticky out-of-range flag
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter int                MEM_DEPTH = 181,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        ir_opcode,
   output logic [DATA_W-1:0] ir_operand,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              fault
);

   // One extra bit so the depth compare never sees a wrapped address.
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic [7:0]        ir_opcode_q, ir_opcode_d;
   logic [DATA_W-1:0] ir_operand_q, ir_operand_d;
   logic              ir_valid_q, ir_valid_d;
   logic              ir_endop_q, ir_endop_d;
   logic              fault_q, fault_d;

   logic              two_word, is_endop;
   logic              fetch_oob, operand_oob;

   instr_fetch_len_decode u_len_decode (
      .opcode_i   (mem_rdata[7:0]),
      .two_word_o (two_word),
      .is_endop_o (is_endop)
   );

   assign fetch_oob   = {1'b0, pc_q} >= DEPTH;
   assign operand_oob = ({1'b0, pc_q} + (ADDR_W+1)'(1)) >= DEPTH;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         ir_pc_q      <= RESET_PC;
         ir_opcode_q  <= '0;
         ir_operand_q <= '0;
         ir_valid_q   <= 1'b0;
         ir_endop_q   <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_pc_q      <= ir_pc_d;
         ir_opcode_q  <= ir_opcode_d;
         ir_operand_q <= ir_operand_d;
         ir_valid_q   <= ir_valid_d;
         ir_endop_q   <= ir_endop_d;
         fault_q      <= fault_d;
      end
   end

   // Next-state and datapath updates. A redirect wins over everything in the
   // active states, including a pending fault check and an endop transfer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_pc_d      = ir_pc_q;
      ir_opcode_d  = ir_opcode_q;
      ir_operand_d = ir_operand_q;
      ir_valid_d   = ir_valid_q;
      ir_endop_d   = ir_endop_q;
      fault_d      = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (redirect_en) begin
               pc_d = redirect_addr;
            end else if (fetch_oob) begin
               fault_d = 1'b1;
               state_d = ST_HALT;
            end else begin
               state_d = ST_OP;
            end
         end
         ST_OP: begin
            if (redirect_en) begin
               pc_d    = redirect_addr;
               state_d = ST_FETCH;
            end else begin
               ir_opcode_d = mem_rdata[7:0];
               ir_endop_d  = is_endop;
               ir_pc_d     = pc_q;
               if (two_word) begin
                  if (operand_oob) begin
                     fault_d = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     pc_d    = pc_q + ADDR_W'(2);
                     state_d = ST_OPD;
                  end
               end else begin
                  ir_operand_d = '0;
                  pc_d         = pc_q + ADDR_W'(1);
                  ir_valid_d   = 1'b1;
                  state_d      = ST_HOLD;
               end
            end
         end
         ST_OPD: begin
            if (redirect_en) begin
               pc_d    = redirect_addr;
               state_d = ST_FETCH;
            end else begin
               ir_operand_d = mem_rdata;
               ir_valid_d   = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_en) begin
               pc_d       = redirect_addr;
               ir_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end else if (ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = ir_endop_q ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            ir_valid_d = 1'b0;
         end
         default: begin
            state_d    = ST_IDLE;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      mem_addr     = (state_q == ST_OP) ? pc_q + ADDR_W'(1) : pc_q;
      mem_write_en = 1'b0;
      // Once the opcode is latched, pc has already moved past the instruction.
      pc_out       = ((state_q == ST_OPD) || (state_q == ST_HOLD)) ? ir_pc_q : pc_q;
      halted       = (state_q == ST_HALT);
      ir_opcode    = ir_opcode_q;
      ir_operand   = ir_operand_q;
      ir_valid     = ir_valid_q;
      fault        = fault_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   localparam int DEPTH = 181;
   localparam int BIG   = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, ir_ready, redirect_en;
   logic [15:0] redirect_addr, mem_rdata, mem_addr, ir_operand, pc_out;
   logic [7:0]  ir_opcode;
   logic        mem_write_en, ir_valid, halted, fault;

   logic [15:0] mem [0:DEPTH-1];

   int tests_run = 0, tests_failed = 0, cyc = 0;

   // Reference model: tracks the program counter of the current instruction
   // and the absolute cycle at which it becomes valid or faults.
   bit          m_run, m_halt, m_fault;
   logic [15:0] m_pc;
   int          m_vld_at, m_halt_at;

   always #5 clk = ~clk;

   // 1-cycle registered-read instruction memory
   always @(posedge clk) mem_rdata <= (mem_addr < 16'(DEPTH)) ? mem[mem_addr] : 16'h0;

   instr_fetch dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
      .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
      .pc_out(pc_out), .halted(halted), .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit two_w(input logic [7:0] op);
      return (op == 8'd38) || (op == 8'd41) || (op == 8'd48) || (op == 8'd49);
   endfunction

   function automatic logic [15:0] rd_mem(input logic [15:0] a);
      return (a < 16'(DEPTH)) ? mem[a] : 16'h0;
   endfunction

   // Instruction fetch begins in the current cycle at address pc.
   task automatic m_restart(input logic [15:0] pc);
      logic [15:0] w;
      m_pc      = pc;
      m_vld_at  = BIG;
      m_halt_at = BIG;
      w         = rd_mem(pc);
      if (pc >= 16'(DEPTH))                       m_halt_at = cyc + 1;
      else if (two_w(w[7:0]) && pc + 1 >= DEPTH)  m_halt_at = cyc + 2;
      else                                        m_vld_at  = cyc + (two_w(w[7:0]) ? 3 : 2);
   endtask

   task automatic model_edge();
      bit          vprev;
      logic [15:0] w;
      vprev = m_run && (m_vld_at <= cyc - 1);
      if (m_halt) begin
      end else if (!m_run) begin
         if (start) begin
            m_run = 1'b1;
            m_restart(16'd0);
         end
      end else if (redirect_en) begin
         m_restart(redirect_addr);
      end else if (vprev && ir_ready) begin
         w = rd_mem(m_pc);
         if (w[7:0] == 8'd51) begin
            m_halt = 1'b1;
            m_run  = 1'b0;
         end else begin
            m_restart(m_pc + (two_w(w[7:0]) ? 16'd2 : 16'd1));
         end
      end
      if (m_run && m_halt_at <= cyc) begin
         m_halt  = 1'b1;
         m_fault = 1'b1;
         m_run   = 1'b0;
      end
   endtask

   task automatic check_cycle();
      bit          ev;
      logic [15:0] w;
      ev = m_run && (m_vld_at <= cyc);
      chk("ir_valid", ir_valid, ev);
      chk("halted", halted, m_halt);
      chk("fault", fault, m_fault);
      chk("mem_we", mem_write_en, 0);
      if (ev) begin
         w = rd_mem(m_pc);
         chk("ir_opcode", ir_opcode, w[7:0]);
         chk("ir_operand", ir_operand, two_w(w[7:0]) ? rd_mem(m_pc + 16'd1) : 16'h0);
         chk("pc_out", pc_out, m_pc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; redirect_en = 1'b0; ir_ready = 1'b0; redirect_addr = '0;
      #2;
      chk("rst_valid", ir_valid, 0);
      chk("rst_opcode", ir_opcode, 0);
      chk("rst_operand", ir_operand, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fault", fault, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_addr", mem_addr, 0);
      m_run = 0; m_halt = 0; m_fault = 0; m_vld_at = BIG; m_halt_at = BIG;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!ir_valid && n < 20) begin tick(); n++; end
      chk(tag, ir_valid, 1);
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 20) begin tick(); n++; end
      chk(tag, halted, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tw [4];
      logic [7:0] op;
      int         r;
      tw = '{8'd38, 8'd41, 8'd48, 8'd49};
      for (int a = 0; a < DEPTH; a++) mem[a] = 16'd9;
      mem[0] = 16'd38; mem[1] = 16'd257; mem[2] = 16'd9;

      // 1: two-word then single-word instruction, latency 3
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      tick(); chk("t1_op_nv", ir_valid, 0);
      tick(); chk("t1_opd_nv", ir_valid, 0);
      tick(); chk("t1_valid", ir_valid, 1);
      chk("t1_opcode", ir_opcode, 38); chk("t1_operand", ir_operand, 257); chk("t1_pc", pc_out, 0);

      // 2: back-pressure keeps everything stable
      repeat (5) begin
         tick();
         chk("t2_valid", ir_valid, 1); chk("t2_opcode", ir_opcode, 38);
         chk("t2_operand", ir_operand, 257); chk("t2_addr", mem_addr, 2);
      end
      ir_ready = 1'b1; tick(); ir_ready = 1'b0;
      tick(); tick();
      chk("t2_next_valid", ir_valid, 1); chk("t2_next_op", ir_opcode, 9);
      chk("t2_next_opd", ir_operand, 0); chk("t2_next_pc", pc_out, 2);

      // 3: redirect on the transfer cycle
      mem[105] = 16'd41; mem[106] = 16'd127;
      redirect_en = 1'b1; redirect_addr = 16'd105; tick(); redirect_en = 1'b0;
      wait_valid("t3_wait");
      chk("t3_opcode", ir_opcode, 41); chk("t3_operand", ir_operand, 127); chk("t3_pc", pc_out, 105);
      ir_ready = 1'b1; redirect_en = 1'b1; redirect_addr = 16'd127; tick();
      ir_ready = 1'b0; redirect_en = 1'b0;
      chk("t3_addr", mem_addr, 127); chk("t3_pcr", pc_out, 127);

      // 4: endop halts; start/redirect ignored; reset recovers
      mem[126] = 16'd51;
      redirect_en = 1'b1; redirect_addr = 16'd126; tick(); redirect_en = 1'b0;
      wait_valid("t4_wait");
      chk("t4_opcode", ir_opcode, 51);
      ir_ready = 1'b1; tick(); ir_ready = 1'b0;
      chk("t4_halt", halted, 1);
      start = 1'b1; redirect_en = 1'b1; redirect_addr = 16'd5; tick();
      start = 1'b0; redirect_en = 1'b0;
      repeat (3) tick();
      chk("t4_still", halted, 1); chk("t4_nv", ir_valid, 0);
      do_reset();

      // 5: operand word beyond memory, then opcode beyond memory
      mem[180] = 16'd49;
      start = 1'b1; tick(); start = 1'b0;
      redirect_en = 1'b1; redirect_addr = 16'd180; tick(); redirect_en = 1'b0;
      wait_halt("t5_halt");
      chk("t5_fault", fault, 1);
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      redirect_en = 1'b1; redirect_addr = 16'd200; tick(); redirect_en = 1'b0;
      wait_halt("t5b_halt");
      chk("t5b_fault", fault, 1); chk("t5b_addr", mem_addr, 200);

      // 6: reset during operand fetch
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      wait_valid("t6_wait");
      chk("t6_opcode", ir_opcode, 38); chk("t6_operand", ir_operand, 257); chk("t6_pc", pc_out, 0);

      // Randomized programs with random back-pressure, redirects and stray starts
      for (int ep = 0; ep < 8; ep++) begin
         for (int a = 0; a < DEPTH; a++) begin
            r = int'($urandom % 40);
            if (r == 0)      op = 8'd51;
            else if (r < 16) op = tw[r % 4];
            else             op = 8'($urandom);
            mem[a] = {8'($urandom), op};
         end
         do_reset();
         start = 1'b1; tick(); start = 1'b0;
         for (int c = 0; c < 400 && !m_halt; c++) begin
            ir_ready    = ($urandom % 3) != 0;
            start       = ($urandom % 10) == 0;
            redirect_en = ($urandom % 20) == 0;
            if ($urandom % 50 == 0)     redirect_addr = 16'hFFFF;
            else if ($urandom % 8 == 0) redirect_addr = 16'($urandom_range(170, 210));
            else                        redirect_addr = 16'($urandom_range(0, 180));
            tick();
         end
         start = 1'b0; redirect_en = 1'b0; ir_ready = 1'b0;
         repeat (3) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
